// File: rtl/norm32_pipe.sv
// norm32_pipe: two-stage valid/ready normalizer. It turns a 32-bit unsigned
// magnitude into mantissa/exponent form and tracks a per-frame block exponent.
//
// Parameters:
//   MANT_W  output mantissa width (2..31)
//
// Ports:
//   clk, rst_n       clock (rising edge), asynchronous active-low reset
//   in_valid/ready   input handshake; in_ready is combinational from out_ready
//   in_data, in_last 32-bit sample and end-of-frame marker
//   out_valid/ready  output handshake
//   out_mant         normalized mantissa (MSB set unless out_zero)
//   out_exp          31 - clz(sample), 0 for a zero sample
//   out_zero         sample was zero
//   out_last         delayed in_last
//   out_frame_exp    max exponent over the frame (valid with out_valid && out_last)
//   out_frame_zero   whole frame was zero (valid with out_valid && out_last)
//
// Build option:
//   NORM32_ROUND_EN  round half-up on the guard bit instead of truncating.
//                    The adder lives in stage 2, so latency stays at 2 cycles.

// Count leading zeros of a 32-bit word; returns 32 for a zero word.
module clz32 (
  input  logic [31:0] data_i,
  output logic [5:0]  clz_o
);

  // Scan from LSB to MSB so the highest set bit writes last and wins.
  always_comb begin
    clz_o = 6'd32;
    for (int i = 0; i < 32; i++) begin
      clz_o = data_i[i] ? 6'(31 - i) : clz_o;
    end
  end

endmodule

module norm32_pipe #(
  parameter int MANT_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [31:0]       in_data,
  input  logic              in_last,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [MANT_W-1:0] out_mant,
  output logic [4:0]        out_exp,
  output logic              out_zero,
  output logic              out_last,
  output logic [4:0]        out_frame_exp,
  output logic              out_frame_zero
);

  // Stage 1 registers
  logic              s1_valid_q;
  logic [31:0]       s1_data_q;
  logic              s1_last_q;

  // Stage 2 registers (drive the outputs directly)
  logic              s2_valid_q;
  logic [MANT_W-1:0] s2_mant_q;
  logic [4:0]        s2_exp_q;
  logic              s2_zero_q;
  logic              s2_last_q;

  // Frame accumulator
  logic [4:0]        acc_exp_q;
  logic              acc_zero_q;

  // Combinational
  logic              s1_en_s;
  logic              s2_en_s;
  logic              out_hs_s;
  logic [5:0]        clz_s;
  logic [31:0]       norm_s;
  logic              zero_s;
  logic [4:0]        exp_t_s;
  logic [MANT_W-1:0] mant_t_s;
  logic [MANT_W-1:0] mant_d;
  logic [4:0]        exp_d;
  logic              zero_d;
  logic [4:0]        cand_exp_s;
  logic              cand_zero_s;
`ifdef NORM32_ROUND_EN
  logic              guard_s;
  logic [MANT_W:0]   sum_s;
`endif

  // A stage may load when it is empty or its contents move on this cycle.
  assign s2_en_s  = !s2_valid_q || out_ready;
  assign s1_en_s  = !s1_valid_q || s2_en_s;
  assign in_ready = s1_en_s && rst_n;
  assign out_hs_s = s2_valid_q && out_ready;

  clz32 u_clz (
    .data_i (s1_data_q),
    .clz_o  (clz_s)
  );

  // Shifting by 32 (zero input) yields an all-zero word, so no special case.
  assign norm_s   = s1_data_q << clz_s;
  assign zero_s   = (clz_s == 6'd32);
  assign exp_t_s  = 5'(6'd31 - clz_s);
  assign mant_t_s = MANT_W'(norm_s >> (32 - MANT_W));

`ifdef NORM32_ROUND_EN
  assign guard_s = norm_s[31-MANT_W];
  assign sum_s   = {1'b0, mant_t_s} + {{MANT_W{1'b0}}, guard_s};
`endif

  // Stage 2 next-state: zero forcing plus optional rounding with carry-out.
  always_comb begin
    mant_d = '0;
    exp_d  = 5'd0;
    zero_d = 1'b0;
    if (zero_s) begin
      mant_d = '0;
      exp_d  = 5'd0;
      zero_d = 1'b1;
    end else begin
`ifdef NORM32_ROUND_EN
      if (sum_s[MANT_W]) begin
        // Mantissa overflowed to 2^MANT_W: renormalize, or saturate at the top.
        if (exp_t_s != 5'd31) begin
          mant_d = {1'b1, {(MANT_W-1){1'b0}}};
          exp_d  = exp_t_s + 5'd1;
        end else begin
          mant_d = {MANT_W{1'b1}};
          exp_d  = 5'd31;
        end
      end else begin
        mant_d = sum_s[MANT_W-1:0];
        exp_d  = exp_t_s;
      end
`else
      mant_d = mant_t_s;
      exp_d  = exp_t_s;
`endif
      zero_d = 1'b0;
    end
  end

  // Frame candidate: current beat folded into the running accumulator.
  always_comb begin
    cand_exp_s  = acc_exp_q;
    cand_zero_s = acc_zero_q && s2_zero_q;
    if (!s2_zero_q && (s2_exp_q > acc_exp_q)) begin
      cand_exp_s = s2_exp_q;
    end else begin
      cand_exp_s = acc_exp_q;
    end
  end

  // Stage 1: capture the incoming sample; bubbles only clear the valid bit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      s1_data_q  <= 32'd0;
      s1_last_q  <= 1'b0;
    end else if (s1_en_s) begin
      s1_valid_q <= in_valid;
      if (in_valid) begin
        s1_data_q <= in_data;
        s1_last_q <= in_last;
      end
    end
  end

  // Stage 2: register the normalized result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid_q <= 1'b0;
      s2_mant_q  <= '0;
      s2_exp_q   <= 5'd0;
      s2_zero_q  <= 1'b0;
      s2_last_q  <= 1'b0;
    end else if (s2_en_s) begin
      s2_valid_q <= s1_valid_q;
      if (s1_valid_q) begin
        s2_mant_q <= mant_d;
        s2_exp_q  <= exp_d;
        s2_zero_q <= zero_d;
        s2_last_q <= s1_last_q;
      end
    end
  end

  // Frame accumulator: advances only on an output handshake, clears after last.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_exp_q  <= 5'd0;
      acc_zero_q <= 1'b1;
    end else if (out_hs_s) begin
      if (s2_last_q) begin
        acc_exp_q  <= 5'd0;
        acc_zero_q <= 1'b1;
      end else begin
        acc_exp_q  <= cand_exp_s;
        acc_zero_q <= cand_zero_s;
      end
    end
  end

  assign out_valid      = s2_valid_q;
  assign out_mant       = s2_mant_q;
  assign out_exp        = s2_exp_q;
  assign out_zero       = s2_zero_q;
  assign out_last       = s2_last_q;
  assign out_frame_exp  = cand_exp_s;
  assign out_frame_zero = cand_zero_s;

endmodule
